// File: rtl/rename_tag_sched_pkg.sv
// Shared types for the rename-stage tag scheduler.
// Holds the register-file tag types, the scheduler FSM state encoding and
// the group-width constants used by the scheduler and its slot selector.
package rename_tag_sched_pkg;

  localparam int NUM_ISSUE = 4;
  localparam int SLOT_W    = $clog2(NUM_ISSUE);
  localparam int CNT_W     = $clog2(NUM_ISSUE + 1);
  localparam int RFTAG_W   = 6;

  // Physical register-file tag handed out by the tag buffer.
  typedef logic [RFTAG_W-1:0] RFTag;
  // Wider tag form used elsewhere in the pipeline (RFTag plus a kind bit).
  typedef logic [RFTAG_W:0]   Tag;

  typedef logic [SLOT_W-1:0]  SlotIdx;
  typedef logic [CNT_W-1:0]   LaneCnt;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    REFILL = 2'd2
  } SchedState_t;

  function automatic LaneCnt popcount(input logic [NUM_ISSUE-1:0] v);
    LaneCnt c;
    c = '0;
    for (int i = 0; i < NUM_ISSUE; i++) c = c + LaneCnt'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/rename_tag_sched_slot_select.sv
// TagSlotSelect: purely combinational mapping of tag-needing lanes onto
// valid tag-buffer slots. The k-th needing lane (from lane 0) is paired
// with the k-th valid slot (from slot 0).
// Ports:
//   slot_valid_i  per-slot valid mask from the tag buffer
//   lane_need_i   per-lane "valid and needs a tag" mask
//   lane_slot_o   per-lane slot index (meaningful only where lane_need_i=1)
//   slot_use_o    per-slot mask of slots that the group would consume
//   fits_o        the group's tag demand fits in the valid slots
module TagSlotSelect
  import rename_tag_sched_pkg::*;
(
  input  logic [NUM_ISSUE-1:0] slot_valid_i,
  input  logic [NUM_ISSUE-1:0] lane_need_i,
  output SlotIdx               lane_slot_o [NUM_ISSUE],
  output logic [NUM_ISSUE-1:0] slot_use_o,
  output logic                 fits_o
);

  LaneCnt slot_rank [NUM_ISSUE];  // valid slots strictly below this slot
  LaneCnt lane_rank [NUM_ISSUE];  // needing lanes strictly below this lane
  LaneCnt need_cnt;
  LaneCnt avail_cnt;

  always_comb begin
    LaneCnt s_acc;
    LaneCnt l_acc;
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves a signal unassigned and no latch is inferred.
    s_acc = '0;
    l_acc = '0;
    for (int i = 0; i < NUM_ISSUE; i++) begin
      slot_rank[i] = s_acc;
      lane_rank[i] = l_acc;
      s_acc = s_acc + LaneCnt'(slot_valid_i[i]);
      l_acc = l_acc + LaneCnt'(lane_need_i[i]);
    end
  end

  assign need_cnt  = popcount(lane_need_i);
  assign avail_cnt = popcount(slot_valid_i);
  assign fits_o    = (need_cnt <= avail_cnt);

  // A valid slot is consumed when its rank is below the total demand:
  // that picks exactly the lowest need_cnt valid slots.
  always_comb begin
    for (int s = 0; s < NUM_ISSUE; s++) begin
      slot_use_o[s] = slot_valid_i[s] && (slot_rank[s] < need_cnt);
    end
  end

  // Lane l takes the valid slot whose rank equals the lane's own rank.
  always_comb begin
    for (int l = 0; l < NUM_ISSUE; l++) begin
      lane_slot_o[l] = '0;
      for (int s = 0; s < NUM_ISSUE; s++) begin
        if (slot_valid_i[s] && (slot_rank[s] == lane_rank[l])) begin
          lane_slot_o[l] = SlotIdx'(s);
        end
      end
    end
  end

endmodule

// File: rtl/rename_tag_sched.sv
// rename_tag_sched: rename-stage scheduler sharing the tag buffer's
// pre-fetched physical-tag slots with one decoded group per cycle.
// Groups are admitted all-or-nothing; slots are consumed in slot order.
// Mispredict recovery (FLUSH, then REFILL_CYCLES of REFILL) blocks all
// slot consumption while the free list is restored.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   IN_mispr           mispredict pulse (highest priority)
//   IN_mispredFlush    post-mispredict flush in progress
//   IN_instrValid      group lane valid, contiguous from lane 0
//   IN_instrNeedsTag   lane writes a register
//   IN_tags            tag-buffer slot tags
//   IN_tagsValid       tag-buffer slot valid
//   OUT_tagUse         combinational per-slot consume strobe
//   OUT_stall          combinational: group not accepted this cycle
//   OUT_instrValid     registered accepted lanes
//   OUT_instrHasTag    registered: lane received a tag
//   OUT_instrTag       registered assigned tag, 0 when none
//   OUT_tagStarved     registered: shortage stall run reached STARVE_THRESH
//   OUT_stallCnt       registered saturating count of shortage-stall cycles
module rename_tag_sched
  import rename_tag_sched_pkg::*;
#(
  parameter int REFILL_CYCLES = 2,
  parameter int STARVE_THRESH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IN_mispr,
  input  logic                 IN_mispredFlush,
  input  logic [NUM_ISSUE-1:0] IN_instrValid,
  input  logic [NUM_ISSUE-1:0] IN_instrNeedsTag,
  input  RFTag                 IN_tags [NUM_ISSUE],
  input  logic [NUM_ISSUE-1:0] IN_tagsValid,
  output logic [NUM_ISSUE-1:0] OUT_tagUse,
  output logic                 OUT_stall,
  output logic [NUM_ISSUE-1:0] OUT_instrValid,
  output logic [NUM_ISSUE-1:0] OUT_instrHasTag,
  output RFTag                 OUT_instrTag [NUM_ISSUE],
  output logic                 OUT_tagStarved,
  output logic [15:0]          OUT_stallCnt
);

  SchedState_t state_q, state_d;
  logic [2:0]  refill_cnt_q, refill_cnt_d;
  logic [7:0]  starve_run_q, starve_run_d;
  logic        starved_q, starved_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [NUM_ISSUE-1:0] lane_valid_q, lane_valid_d;
  logic [NUM_ISSUE-1:0] lane_has_q, lane_has_d;
  RFTag                 lane_tag_q [NUM_ISSUE];
  RFTag                 lane_tag_d [NUM_ISSUE];

  logic [NUM_ISSUE-1:0] lane_need;
  SlotIdx               lane_slot [NUM_ISSUE];
  logic [NUM_ISSUE-1:0] slot_use;
  logic                 fits;
  logic                 admit_ok;
  logic                 accept;
  logic                 shortage;

  assign lane_need = IN_instrValid & IN_instrNeedsTag;

  TagSlotSelect u_slot_select (
    .slot_valid_i (IN_tagsValid),
    .lane_need_i  (lane_need),
    .lane_slot_o  (lane_slot),
    .slot_use_o   (slot_use),
    .fits_o       (fits)
  );

  // Admission window: RUN with no mispredict and no flush. Reset is folded
  // in so no use strobe can leak out during the reset cycle.
  assign admit_ok = !rst && (state_q == RUN) && !IN_mispr && !IN_mispredFlush;
  assign accept   = admit_ok && fits;
  assign shortage = admit_ok && !fits;

  assign OUT_tagUse = accept ? slot_use : '0;
  assign OUT_stall  = !accept && ((|IN_instrValid) || (state_q != RUN));

  // Recovery sequencing.
  always_comb begin
    state_d      = state_q;
    refill_cnt_d = refill_cnt_q;
    if (IN_mispr) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        RUN: ;
        FLUSH: begin
          if (!IN_mispredFlush) begin
            refill_cnt_d = 3'(REFILL_CYCLES);
            state_d      = REFILL;
          end
        end
        REFILL: begin
          if (IN_mispredFlush) begin
            state_d = FLUSH;
          end else begin
            refill_cnt_d = refill_cnt_q - 3'd1;
            if (refill_cnt_q == 3'd1) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Starvation tracking. The flag is registered from the next run value so
  // it rises on the same edge that counts the threshold-th stall cycle.
  always_comb begin
    starve_run_d = '0;
    stall_cnt_d  = stall_cnt_q;
    if (shortage) begin
      starve_run_d = (starve_run_q == 8'hFF) ? starve_run_q : starve_run_q + 8'd1;
      if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end
    starved_d = (32'(starve_run_d) >= STARVE_THRESH);
  end

  // Accepted group capture; anything else clears the lane registers.
  always_comb begin
    lane_valid_d = '0;
    lane_has_d   = '0;
    for (int l = 0; l < NUM_ISSUE; l++) lane_tag_d[l] = '0;
    if (accept) begin
      lane_valid_d = IN_instrValid;
      lane_has_d   = lane_need;
      for (int l = 0; l < NUM_ISSUE; l++) begin
        if (lane_need[l]) lane_tag_d[l] = IN_tags[lane_slot[l]];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      refill_cnt_q <= '0;
      starve_run_q <= '0;
      starved_q    <= 1'b0;
      stall_cnt_q  <= '0;
      lane_valid_q <= '0;
      lane_has_q   <= '0;
      // NOTE: the per-lane tag array is architecturally visible after reset,
      // so it is reset explicitly rather than left as uninitialised storage.
      for (int l = 0; l < NUM_ISSUE; l++) lane_tag_q[l] <= '0;
    end else begin
      state_q      <= state_d;
      refill_cnt_q <= refill_cnt_d;
      starve_run_q <= starve_run_d;
      starved_q    <= starved_d;
      stall_cnt_q  <= stall_cnt_d;
      lane_valid_q <= lane_valid_d;
      lane_has_q   <= lane_has_d;
      for (int l = 0; l < NUM_ISSUE; l++) lane_tag_q[l] <= lane_tag_d[l];
    end
  end

  assign OUT_instrValid  = lane_valid_q;
  assign OUT_instrHasTag = lane_has_q;
  assign OUT_instrTag    = lane_tag_q;
  assign OUT_tagStarved  = starved_q;
  assign OUT_stallCnt    = stall_cnt_q;

  // The tag buffer must never be told to consume an empty slot.
  always_ff @(posedge clk) begin
    assert ((OUT_tagUse & ~IN_tagsValid) == '0);
  end

endmodule

// File: tb/tb_rename_tag_sched.sv
// Self-checking bench for rename_tag_sched: directed vector table,
// hand-written recovery/starvation sequences and a randomized run, all
// cross-checked every cycle against a behavioural model.
module tb_rename_tag_sched;
  import rename_tag_sched_pkg::*;

  localparam int N  = NUM_ISSUE;
  localparam int RC = 2;
  localparam int ST = 8;

  logic         clk = 1'b0;
  logic         rst, mispr, flush;
  logic [N-1:0] valid, needs, tvalid;
  RFTag         tags [N];
  logic [N-1:0] use_o;
  logic         stall_o;
  logic [N-1:0] ivalid_o, has_o;
  RFTag         tag_o [N];
  logic         starved_o;
  logic [15:0]  cnt_o;

  always #5 clk = ~clk;

  rename_tag_sched #(.REFILL_CYCLES(RC), .STARVE_THRESH(ST)) dut (
    .clk              (clk),
    .rst              (rst),
    .IN_mispr         (mispr),
    .IN_mispredFlush  (flush),
    .IN_instrValid    (valid),
    .IN_instrNeedsTag (needs),
    .IN_tags          (tags),
    .IN_tagsValid     (tvalid),
    .OUT_tagUse       (use_o),
    .OUT_stall        (stall_o),
    .OUT_instrValid   (ivalid_o),
    .OUT_instrHasTag  (has_o),
    .OUT_instrTag     (tag_o),
    .OUT_tagStarved   (starved_o),
    .OUT_stallCnt     (cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: m_wait = 0 running, -1 flushing, >0 refill cycles left.
  int           m_wait = 0;
  int           m_starve = 0;
  int           m_cnt = 0;
  bit           m_starved = 0;
  logic [N-1:0] m_valid = '0, m_has = '0;
  RFTag         m_tag [N] = '{default: '0};

  logic [N-1:0] s_use;
  logic         s_stall;

  // Inputs are already driven; checks combinational outputs, crosses the
  // edge, then checks the registered outputs.
  task automatic step();
    int           need, avail, k;
    bit           running, ok, acc, shrt;
    logic [N-1:0] e_use;
    logic         e_stall;
    int           q[$];
    RFTag         lt [N];
    #1;
    need    = $countones(valid & needs);
    avail   = $countones(tvalid);
    running = (m_wait == 0);
    ok      = !rst && running && !mispr && !flush;
    acc     = ok && (need <= avail);
    shrt    = ok && (need > avail);
    e_use   = '0;
    for (int s = 0; s < N; s++) if (tvalid[s]) q.push_back(s);
    if (acc) for (int i = 0; i < need; i++) e_use[q[i]] = 1'b1;
    k = 0;
    for (int l = 0; l < N; l++) begin
      lt[l] = '0;
      if (acc && valid[l] && needs[l]) begin
        lt[l] = tags[q[k]];
        k++;
      end
    end
    e_stall = !acc && ((|valid) || !running);
    check("tag_use", use_o, e_use);
    if (!rst) check("stall", stall_o, e_stall);
    s_use   = use_o;
    s_stall = stall_o;
    @(posedge clk);
    #1;
    if (rst) begin
      m_wait = 0; m_starve = 0; m_cnt = 0; m_starved = 0;
      m_valid = '0; m_has = '0;
      for (int l = 0; l < N; l++) m_tag[l] = '0;
    end else begin
      if (shrt) begin
        m_starve = (m_starve < 255) ? m_starve + 1 : 255;
        m_cnt    = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else begin
        m_starve = 0;
      end
      m_starved = (m_starve >= ST);
      m_valid   = acc ? valid : '0;
      m_has     = acc ? (valid & needs) : '0;
      for (int l = 0; l < N; l++) m_tag[l] = lt[l];
      if (mispr)             m_wait = -1;
      else if (m_wait == -1) begin if (!flush) m_wait = RC; end
      else if (m_wait > 0)   m_wait = flush ? -1 : m_wait - 1;
    end
    check("instr_valid", ivalid_o, m_valid);
    check("instr_has_tag", has_o, m_has);
    for (int l = 0; l < N; l++) check($sformatf("instr_tag%0d", l), tag_o[l], m_tag[l]);
    check("tag_starved", starved_o, m_starved);
    check("stall_cnt", cnt_o, m_cnt);
  endtask

  task automatic drive(input logic r, input logic m, input logic f,
                       input logic [N-1:0] v, input logic [N-1:0] n, input logic [N-1:0] tv);
    rst = r; mispr = m; flush = f; valid = v; needs = n; tvalid = tv;
  endtask

  task automatic full_group();
    for (int l = 0; l < N; l++) tags[l] = RFTag'(10 + l);
    drive(0, 0, 0, 4'b1111, 4'b1111, 4'b1111);
  endtask

  typedef struct {
    string                      name;
    logic [N-1:0]               valid, needs, tvalid;
    logic [N-1:0][RFTAG_W-1:0]  tags;
    logic [N-1:0]               e_use;
    logic                       e_stall;
    logic [N-1:0]               e_valid, e_has;
    logic [N-1:0][RFTAG_W-1:0]  e_tags;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{name:"all4", valid:4'b1111, needs:4'b1111, tvalid:4'b1111,
      tags:{6'd13,6'd12,6'd11,6'd10}, e_use:4'b1111, e_stall:1'b0,
      e_valid:4'b1111, e_has:4'b1111, e_tags:{6'd13,6'd12,6'd11,6'd10}});
    vecs.push_back('{name:"sparse", valid:4'b0111, needs:4'b0101, tvalid:4'b1010,
      tags:{6'd7,6'd2,6'd5,6'd1}, e_use:4'b1010, e_stall:1'b0,
      e_valid:4'b0111, e_has:4'b0101, e_tags:{6'd0,6'd7,6'd0,6'd5}});
    vecs.push_back('{name:"empty", valid:4'b0000, needs:4'b1111, tvalid:4'b0000,
      tags:{6'd3,6'd3,6'd3,6'd3}, e_use:4'b0000, e_stall:1'b0,
      e_valid:4'b0000, e_has:4'b0000, e_tags:'0});
    vecs.push_back('{name:"mid", valid:4'b1111, needs:4'b0110, tvalid:4'b1100,
      tags:{6'd21,6'd20,6'd9,6'd8}, e_use:4'b1100, e_stall:1'b0,
      e_valid:4'b1111, e_has:4'b0110, e_tags:{6'd0,6'd21,6'd20,6'd0}});
    vecs.push_back('{name:"short", valid:4'b0011, needs:4'b0011, tvalid:4'b0001,
      tags:{6'd4,6'd3,6'd2,6'd1}, e_use:4'b0000, e_stall:1'b1,
      e_valid:4'b0000, e_has:4'b0000, e_tags:'0});
    vecs.push_back('{name:"notags", valid:4'b0011, needs:4'b0000, tvalid:4'b0000,
      tags:{6'd4,6'd3,6'd2,6'd1}, e_use:4'b0000, e_stall:1'b0,
      e_valid:4'b0011, e_has:4'b0000, e_tags:'0});

    for (int l = 0; l < N; l++) tags[l] = '0;
    drive(1, 0, 0, '0, '0, '0);
    step();
    check("rst_valid", ivalid_o, 4'b0000);
    check("rst_cnt", cnt_o, 16'd0);
    check("rst_starved", starved_o, 1'b0);

    // Directed vectors.
    foreach (vecs[i]) begin
      for (int l = 0; l < N; l++) tags[l] = vecs[i].tags[l];
      drive(0, 0, 0, vecs[i].valid, vecs[i].needs, vecs[i].tvalid);
      step();
      check({vecs[i].name, "_use"}, s_use, vecs[i].e_use);
      check({vecs[i].name, "_stall"}, s_stall, vecs[i].e_stall);
      check({vecs[i].name, "_valid"}, ivalid_o, vecs[i].e_valid);
      check({vecs[i].name, "_has"}, has_o, vecs[i].e_has);
      for (int l = 0; l < N; l++)
        check($sformatf("%s_tag%0d", vecs[i].name, l), tag_o[l], vecs[i].e_tags[l]);
    end

    // Starvation: 8 shortage cycles, then one accepted cycle.
    drive(1, 0, 0, '0, '0, '0);
    step();
    for (int c = 1; c <= 8; c++) begin
      drive(0, 0, 0, 4'b0011, 4'b0011, 4'b0001);
      step();
      check("starve_stall", s_stall, 1'b1);
      check("starve_use", s_use, 4'b0000);
      if (c == 7) check("starve_flag_7", starved_o, 1'b0);
    end
    check("starve_cnt8", cnt_o, 16'd8);
    check("starve_flag_8", starved_o, 1'b1);
    drive(0, 0, 0, 4'b0000, 4'b0000, 4'b0001);
    step();
    check("starve_flag_clr", starved_o, 1'b0);
    check("starve_cnt_hold", cnt_o, 16'd8);

    // Mispredict at t, flush t+1..t+2, first accept at t+6.
    full_group();
    step();
    mispr = 1'b1;
    step();
    check("mispr_stall", s_stall, 1'b1);
    check("mispr_use", s_use, 4'b0000);
    check("mispr_clear", ivalid_o, 4'b0000);
    mispr = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      flush = (c <= 2);
      step();
      check($sformatf("recov_stall_t%0d", c), s_stall, 1'b1);
      check($sformatf("recov_use_t%0d", c), s_use, 4'b0000);
    end
    flush = 1'b0;
    step();
    check("recov_accept_stall", s_stall, 1'b0);
    check("recov_accept_use", s_use, 4'b1111);

    // Flush reasserted during REFILL restarts the full wait.
    mispr = 1'b1; step(); mispr = 1'b0;
    flush = 1'b1; step();
    flush = 1'b0; step();
    flush = 1'b1; step();
    check("reflush_stall", s_stall, 1'b1);
    flush = 1'b0; step();
    for (int c = 0; c < RC; c++) begin
      step();
      check($sformatf("reflush_wait%0d", c), s_stall, 1'b1);
      check($sformatf("reflush_wuse%0d", c), s_use, 4'b0000);
    end
    step();
    check("reflush_accept", s_use, 4'b1111);

    // Reset in REFILL with a pending stall (stallCnt is 8 here).
    mispr = 1'b1; step(); mispr = 1'b0;
    step();
    drive(1, 0, 0, 4'b0011, 4'b0011, 4'b0001);
    step();
    check("rstrf_cnt", cnt_o, 16'd0);
    check("rstrf_valid", ivalid_o, 4'b0000);
    check("rstrf_starved", starved_o, 1'b0);
    full_group();
    step();
    check("rstrf_accept_stall", s_stall, 1'b0);
    check("rstrf_accept_use", s_use, 4'b1111);
    rst = 1'b1;
    step();
    check("rst_no_use", s_use, 4'b0000);

    // Randomized run against the model.
    for (int c = 0; c < 600; c++) begin
      for (int l = 0; l < N; l++) tags[l] = RFTag'($urandom_range(0, 63));
      rst    = ($urandom_range(0, 99) == 0);
      mispr  = ($urandom_range(0, 19) == 0);
      flush  = ($urandom_range(0, 4) == 0);
      valid  = N'((1 << $urandom_range(0, N)) - 1);
      needs  = N'($urandom);
      tvalid = N'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
